priority_arbiter: RTL and testbench

//  Registered, parametrised N-way arbiter; sequential successor to the combinational priority encoders.
//  - Selects one requester per cycle and registers a one-hot grant plus a binary grant index.
//  - Two selection modes: fixed priority (highest index wins) and round-robin (rotating pointer).
//  - The owner may hold the grant across cycles, bounded by MAX_HOLD, to prevent starvation.
//  - Sits in front of shared resources (bus, memory port, FIFO write side) with several requesters.

---
 rtl/priority_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_priority_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter.sv
// ---------------------------------------------------------------------------
// priority_arbiter
//   Registered N-way arbiter. It chooses one requester per cycle and registers
//   a one-hot grant together with the binary index of the winner. Selection is
//   either fixed priority (highest index wins) or round-robin (rotating
//   pointer). The current owner keeps the grant while it requests. If another
//   requester is waiting, the owner is preempted after MAX_HOLD consecutive
//   cycles.
//
// Parameters
//   NUM_INPUTS   number of requesters (>= 2)
//   ROUND_ROBIN  1 = round-robin selection, 0 = fixed priority
//   MAX_HOLD     max consecutive grant cycles while others wait; 0 = unlimited
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req          in   [NUM_INPUTS-1:0] request vector
//   grant        out  [NUM_INPUTS-1:0] one-hot grant, zero when idle
//   grant_idx    out  [IDX_W-1:0] index of granted requester, 0 when idle
//   grant_valid  out  1 while a grant is active
// ---------------------------------------------------------------------------
module priority_arbiter #(
   parameter int NUM_INPUTS  = 4,
   parameter int ROUND_ROBIN = 1,
   parameter int MAX_HOLD    = 8,
   localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_INPUTS-1:0] req,
   output logic [NUM_INPUTS-1:0] grant,
   output logic [IDX_W-1:0]      grant_idx,
   output logic                  grant_valid
);

   localparam int CNT_RAW = $clog2(MAX_HOLD + 1);
   localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

   // Preemption threshold.
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
   // Value at which the counter stops counting. With unlimited hold the
   // counter only has to avoid wrapping, so it stops at all-ones.
   localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                r_state;
   logic [NUM_INPUTS-1:0] r_grant;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_valid;
   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_ptr;

   state_t                w_state_next;
   logic [NUM_INPUTS-1:0] w_grant_next;
   logic [IDX_W-1:0]      w_idx_next;
   logic                  w_valid_next;
   logic [CNT_W-1:0]      w_cnt_next;
   logic [IDX_W-1:0]      w_ptr_next;

   logic                  w_new_grant;
   logic [IDX_W-1:0]      w_new_idx;

   // {found, index}: winner among the bits of v.
   function automatic logic [IDX_W:0] f_select(input logic [NUM_INPUTS-1:0] v,
                                               input logic [IDX_W-1:0]      ptr);
      logic             found;
      logic [IDX_W-1:0] idx;
      int               pos;
      found = 1'b0;
      idx   = '0;
      if (ROUND_ROBIN != 0) begin
         // First set bit when scanning upward from ptr, with wrap-around.
         for (int k = 0; k < NUM_INPUTS; k++) begin
            pos = (int'(ptr) + k) % NUM_INPUTS;
            if (!found && v[pos]) begin
               found = 1'b1;
               idx   = IDX_W'(pos);
            end
         end
      end else begin
         // Ascending scan; the last hit is the highest set index.
         for (int k = 0; k < NUM_INPUTS; k++) begin
            if (v[k]) begin
               found = 1'b1;
               idx   = IDX_W'(k);
            end
         end
      end
      return {found, idx};
   endfunction

   logic [IDX_W:0] w_sel_all;   // winner among all requesters
   logic [IDX_W:0] w_sel_oth;   // winner with the current owner masked out

   assign w_sel_all = f_select(req, r_ptr);
   assign w_sel_oth = f_select(req & ~r_grant, r_ptr);

   always_comb begin
      w_state_next = r_state;
      w_grant_next = r_grant;
      w_idx_next   = r_idx;
      w_valid_next = r_valid;
      w_cnt_next   = r_cnt;
      w_ptr_next   = r_ptr;
      w_new_grant  = 1'b0;
      w_new_idx    = '0;

      case (r_state)
         IDLE: begin
            if (w_sel_all[IDX_W]) begin
               w_new_grant = 1'b1;
               w_new_idx   = w_sel_all[IDX_W-1:0];
            end
         end
         GRANT: begin
            if (!req[r_idx]) begin
               // The owner released the grant. Hand over in the same cycle
               // if anyone else is waiting.
               if (w_sel_all[IDX_W]) begin
                  w_new_grant = 1'b1;
                  w_new_idx   = w_sel_all[IDX_W-1:0];
               end else begin
                  w_state_next = IDLE;
                  w_grant_next = '0;
                  w_idx_next   = '0;
                  w_valid_next = 1'b0;
                  w_cnt_next   = '0;
               end
            end else if ((MAX_HOLD != 0) && (r_cnt == HOLD_LIM) && w_sel_oth[IDX_W]) begin
               w_new_grant = 1'b1;
               w_new_idx   = w_sel_oth[IDX_W-1:0];
            end else if (r_cnt != HOLD_SAT) begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase

      // Every new grant restarts the hold count and moves the pointer past
      // the winner. Hold cycles leave the pointer unchanged.
      if (w_new_grant) begin
         w_state_next            = GRANT;
         w_grant_next            = '0;
         w_grant_next[w_new_idx] = 1'b1;
         w_idx_next              = w_new_idx;
         w_valid_next            = 1'b1;
         w_cnt_next              = CNT_W'(1);
         if (w_new_idx == IDX_W'(NUM_INPUTS - 1)) begin
            w_ptr_next = '0;
         end else begin
            w_ptr_next = w_new_idx + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_next;
         r_grant <= w_grant_next;
         r_idx   <= w_idx_next;
         r_valid <= w_valid_next;
         r_cnt   <= w_cnt_next;
         r_ptr   <= w_ptr_next;
      end
   end

   assign grant       = r_grant;
   assign grant_idx   = r_idx;
   assign grant_valid = r_valid;

endmodule

// File: tb/tb_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tb_priority_arbiter
//   Drives five arbiters with different settings from one request vector.
//   The bench keeps an owner/held/pointer reference model for each arbiter
//   and checks every cycle against it. Hand-computed expectations cover the
//   reset, fixed, round-robin, starvation, unlimited-hold and idle scenarios.
//   Instances: 0 rr/hold8, 1 fixed/hold8, 2 rr/hold3, 3 rr/unlimited,
//              4 fixed/hold3.
// ---------------------------------------------------------------------------
module tb_priority_arbiter;

   localparam int NI = 5;
   localparam int N  = 4;

   function automatic int p_rr(int i);
      return (i == 1 || i == 4) ? 0 : 1;
   endfunction

   function automatic int p_hold(int i);
      if (i == 2 || i == 4) return 3;
      if (i == 3) return 0;
      return 8;
   endfunction

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] d_grant [NI];
   logic [1:0]   d_idx   [NI];
   logic         d_valid [NI];

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_dut
         priority_arbiter #(
            .NUM_INPUTS  (N),
            .ROUND_ROBIN (p_rr(gi)),
            .MAX_HOLD    (p_hold(gi))
         ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req         (req),
            .grant       (d_grant[gi]),
            .grant_idx   (d_idx[gi]),
            .grant_valid (d_valid[gi])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Reference model: owner (-1 = none), cycles held so far (unbounded),
   // and the round-robin start position.
   int m_owner [NI];
   int m_held  [NI];
   int m_ptr   [NI];

   task automatic chk(input string name, input int i, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s inst=%0d t=%0t got=%0d expected=%0d", name, i, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_owner[i] = -1;
         m_held[i]  = 0;
         m_ptr[i]   = 0;
      end
   endtask

   function automatic int sel(int i, logic [N-1:0] v);
      if (p_rr(i) == 0) begin
         for (int b = N - 1; b >= 0; b--) if (v[b]) return b;
      end else begin
         for (int k = 0; k < N; k++) if (v[(m_ptr[i] + k) % N]) return (m_ptr[i] + k) % N;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [N-1:0] r);
      int w;
      logic [N-1:0] others;
      for (int i = 0; i < NI; i++) begin
         w = -1;
         if (m_owner[i] < 0) begin
            w = sel(i, r);
         end else if (!r[m_owner[i]]) begin
            w = sel(i, r);
            if (w < 0) m_owner[i] = -1;
         end else begin
            others = r & ~(4'b0001 << m_owner[i]);
            if (p_hold(i) != 0 && m_held[i] >= p_hold(i) && others != 0) w = sel(i, others);
            else m_held[i]++;
         end
         if (w >= 0) begin
            m_owner[i] = w;
            m_held[i]  = 1;
            m_ptr[i]   = (w + 1) % N;
         end
      end
   endtask

   // Compare process: every falling edge, all instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            chk("mdl_grant", i, d_grant[i], (m_owner[i] < 0) ? 0 : (1 << m_owner[i]));
            chk("mdl_idx",   i, d_idx[i],   (m_owner[i] < 0) ? 0 : m_owner[i]);
            chk("mdl_valid", i, d_valid[i], (m_owner[i] < 0) ? 0 : 1);
         end
      end
   end

   // Hand-computed expectation for one instance.
   task automatic lit(input string name, input int i, input int e_idx, input bit e_valid);
      logic [N-1:0] eg;
      eg = e_valid ? (4'b0001 << e_idx) : 4'b0000;
      chk({name, "_grant"}, i, d_grant[i], eg);
      chk({name, "_idx"},   i, d_idx[i],   e_idx);
      chk({name, "_valid"}, i, d_valid[i], e_valid);
   endtask

   // One clock: drive req, let the DUT sample it, advance the model.
   // Returns 1 time unit after the rising edge.
   task automatic cycle(input logic [N-1:0] r);
      req = r;
      @(posedge clk);
      model_step(r);
      #1;
      $display("cyc t=%0t req=%b idx=%0d/%0d/%0d/%0d/%0d", $time, r,
               d_idx[0], d_idx[1], d_idx[2], d_idx[3], d_idx[4]);
   endtask

   // Asynchronous reset asserted between clock edges; the outputs must clear
   // before the next edge.
   task automatic do_reset(input string name);
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < NI; i++) lit(name, i, 0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Brings every instance to idle with the round-robin pointer at 0.
   task automatic settle();
      cycle(4'b0000);
      cycle(4'b1000);
      cycle(4'b0000);
   endtask

   logic [N-1:0] rq;

   initial begin
      rst_n = 1'b0;
      req   = '0;
      model_reset();
      chk_en = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) lit("reset", i, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle behaviour on the round-robin instance.
      cycle(4'b0001); lit("t6_first", 0, 0, 1'b1);
      cycle(4'b0000); lit("t6_drop",  0, 0, 1'b0);
      cycle(4'b0100); lit("t6_again", 0, 2, 1'b1);

      // Reset in the middle of a grant (instance 0 holds 0100 here).
      #1;
      do_reset("t1_async");

      // Round-robin rotation; the first winner 0 confirms the pointer reset.
      cycle(4'b1111); lit("t3_rr0", 0, 0, 1'b1);
      cycle(4'b1110); lit("t3_rr1", 0, 1, 1'b1);
      cycle(4'b1101); lit("t3_rr2", 0, 2, 1'b1);
      cycle(4'b1011); lit("t3_rr3", 0, 3, 1'b1);
      cycle(4'b0111); lit("t3_wrap", 0, 0, 1'b1);

      // Fixed priority with a handover that has no idle cycle.
      settle();
      cycle(4'b1011); lit("t2_hi",  1, 3, 1'b1);
      cycle(4'b0011); lit("t2_nxt", 1, 1, 1'b1);

      // Starvation limit 3 against unlimited hold.
      settle();
      for (int c = 0; c < 20; c++) begin
         cycle(4'b0011);
         lit("t4_starve", 2, (c / 3) % 2, 1'b1);
         lit("t5_unlim",  3, 0, 1'b1);
      end

      // Random traffic, with the occasional asynchronous reset.
      rq = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 40) begin
            rq = N'($urandom);
            if ($urandom_range(0, 9) == 0) rq = '0;
         end
         if ($urandom_range(0, 299) == 0) begin
            #($urandom_range(0, 2));
            do_reset("rnd_reset");
         end
         cycle(rq);
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
